audio_stream_ctrl: RTL
======================

# audio_stream_ctrl

Sequencer for the codec audio path. It pops one stereo frame from the I2S receive FIFO and routes it through the per-channel effect pipeline, or around it for bypass and mute. It waits the effect's fixed latency and pushes the result into the I2S transmit FIFO. It sits between `i2s_rx`, the effect instances and `i2s_tx`. It replaces free-running read/write strobes with a single-frame-in-flight handshake.

## Interface
- `DATA_WIDTH`, 32: frame width; `[31:16]` is the left channel, `[15:0]` the right channel.
- `FX_LATENCY`, 2: cycles from the `fx_in_valid` cycle to valid `fx_out_data`. Legal range is 0..15.
- `DROP_CNT_W`, 16: width of the dropped-frame counter.

Ports:
- `clk`  in  1: system clock; it is also the read clock of the rx FIFO and the write clock of the tx FIFO.
- `reset_n`  in  1: asynchronous, active-low reset.
- `init_done`  in  1: codec I2C configuration complete; it gates new frames.
- `bypass`  in  1: route the frame around the effect.
- `mute`  in  1: output zero frames; it takes precedence over `bypass`.
- `adcfifo_empty`  in  1: rx FIFO empty.
- `adcfifo_read`  out  1: rx FIFO pop strobe.
- `adcfifo_readdata`  in  DATA_WIDTH: rx FIFO data. The FIFO is non-show-ahead: data is valid the cycle after `adcfifo_read`.
- `fx_in_valid`  out  1: one-cycle strobe marking the start of effect processing.
- `fx_in_data`  out  DATA_WIDTH: frame presented to the effect; held stable for the whole FX state.
- `fx_out_data`  in  DATA_WIDTH: effect result.
- `dacfifo_full`  in  1: tx FIFO full.
- `dacfifo_write`  out  1: tx FIFO push strobe.
- `dacfifo_writedata`  out  DATA_WIDTH: tx FIFO data.
- `busy`  out  1: a frame is in flight (state is not IDLE).
- `drop_count`  out  DROP_CNT_W: number of dropped frames; saturates at its maximum.

## Operation
- The FSM states are IDLE, READ, CAPT, FX and PUSH. Exactly one frame is in flight at a time.
- IDLE: when `init_done` is 1 and `adcfifo_empty` is 0, go to READ. Otherwise stay in IDLE.
- READ: `adcfifo_read` = 1 for exactly this cycle. Always go to CAPT.
- CAPT: capture `adcfifo_readdata` and sample `mute` and `bypass` once; the mode then stays fixed for this frame.
  - If `mute` is 1: `out_q` ← 0, go to PUSH.
  - Else if `bypass` is 1: `out_q` ← data, go to PUSH.
  - Else: `fx_q` ← data, `cnt` ← FX_LATENCY, go to FX.
- FX: `fx_in_data` = `fx_q`. `fx_in_valid` = 1 only in the first FX cycle.
  - If `cnt` is 0: `out_q` ← `fx_out_data`, go to PUSH.
  - Else decrement `cnt`.
- PUSH: `dacfifo_writedata` = `out_q`. `dacfifo_write` = (state is PUSH) and `dacfifo_full` is 0.
  - If the write occurs, go to IDLE.
  - If `dacfifo_full` is 1 and `adcfifo_empty` is 0, a newer frame is waiting. Drop the held frame: no write, increment `drop_count` (saturating), go to IDLE.
  - If `dacfifo_full` is 1 and `adcfifo_empty` is 1, stay in PUSH.
- `init_done` falling mid-frame: the current frame completes normally. The FSM then remains in IDLE.
- Mode inputs changing after CAPT have no effect until the next frame.
- Data is passed through unmodified. There is no arithmetic on samples.

## Timing
- Reset values: state = IDLE; `adcfifo_read`, `fx_in_valid`, `dacfifo_write` and `busy` = 0; `fx_in_data`, `dacfifo_writedata` and `drop_count` = 0; `cnt` = 0.
- Reset asserted mid-frame abandons the frame. There is no write and no drop count.
- Timeline, with cycle 0 being IDLE with the start condition true:
  - Bypass or mute: cycle 1 READ, cycle 2 CAPT, cycle 3 PUSH. The write occurs in cycle 3 if the tx FIFO is not full. Minimum period is 4 cycles per frame.
  - Effect: FX spans cycles 3..3+FX_LATENCY, with `fx_in_valid` in cycle 3. PUSH is cycle 4+FX_LATENCY. With FX_LATENCY = 0, FX lasts 1 cycle.
- `adcfifo_read` and `fx_in_valid` are never asserted for more than 1 consecutive cycle.
- At most 1 `dacfifo_write` per `adcfifo_read`.
- `dacfifo_full` and `adcfifo_empty` are assumed synchronous to `clk`. The FIFOs handle their own clock-domain crossing.

## Structure
- Shared package `audio_pkg`:
  - the FSM state enum;
  - constants for the left and right channel slice positions;
  - the default `DATA_WIDTH`.
- One sub-module, `sat_counter`: a parameterised-width saturating counter with an increment enable, used for `drop_count`.
- The FSM and datapath registers live in `audio_stream_ctrl`.

## Test plan
- Bypass, single frame `32'h1234_ABCD`, tx FIFO not full:
  - `adcfifo_read` is high 1 cycle after start;
  - `dacfifo_write` occurs in cycle 3 with `32'h1234_ABCD`;
  - `busy` falls in the following cycle.
- Effect path, FX_LATENCY = 2, effect model returning `frame ^ 32'hFFFF_0000`, input `32'h0001_0002`:
  - `fx_in_valid` is high in cycle 3 only;
  - the write occurs in cycle 6 with `32'hFFFE_0002`.
- Mute and bypass both high, input `32'hDEAD_BEEF`:
  - the write data is `32'h0000_0000`;
  - `fx_in_valid` is never asserted.
- Tx FIFO full for 10 cycles with rx FIFO empty:
  - the FSM holds in PUSH;
  - the write occurs on the first not-full cycle;
  - `drop_count` stays 0.
- Tx FIFO full and rx FIFO non-empty during PUSH:
  - the frame is dropped and `drop_count` goes 0 → 1;
  - the next frame is read;
  - with DROP_CNT_W = 2, forcing 5 drops leaves `drop_count` saturated at 3.
- `init_done` low: no reads while the rx FIFO is non-empty.
- `reset_n` pulsed in the FX state: all outputs return to 0 and there is no write.
- After reset, streaming 8 frames in bypass produces 8 writes in order.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the codec audio streaming path.
package audio_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Stereo frame layout: left channel in the upper half, right in the lower
  localparam int unsigned LEFT_MSB  = 31;
  localparam int unsigned LEFT_LSB  = 16;
  localparam int unsigned RIGHT_MSB = 15;
  localparam int unsigned RIGHT_LSB = 0;

  // Effect latency counter; FX_LATENCY is limited to 0..15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_FX,
    ST_PUSH
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/audio_stream_ctrl.sv
// Single-frame-in-flight sequencer: rx FIFO -> effect (or bypass/mute) -> tx FIFO.
module audio_stream_ctrl
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FX_LATENCY = 2,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_done,
  input  logic                  bypass,
  input  logic                  mute,
  input  logic                  adcfifo_empty,
  output logic                  adcfifo_read,
  input  logic [DATA_WIDTH-1:0] adcfifo_readdata,
  output logic                  fx_in_valid,
  output logic [DATA_WIDTH-1:0] fx_in_data,
  input  logic [DATA_WIDTH-1:0] fx_out_data,
  input  logic                  dacfifo_full,
  output logic                  dacfifo_write,
  output logic [DATA_WIDTH-1:0] dacfifo_writedata,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  state_e                state_q;
  state_e                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] fx_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  fx_valid_q;
  logic                  drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a held frame is dropped only when the tx FIFO is full and a newer frame waits
  always_comb begin
    state_d = state_q;
    drop    = 1'b0;
    case (state_q)
      ST_IDLE: if (init_done && !adcfifo_empty) state_d = ST_READ;
      ST_READ: state_d = ST_CAPT;
      ST_CAPT: state_d = (mute || bypass) ? ST_PUSH : ST_FX;
      ST_FX:   if (cnt_q == '0) state_d = ST_PUSH;
      ST_PUSH: begin
        if (!dacfifo_full) begin
          state_d = ST_IDLE;
        end else if (!adcfifo_empty) begin
          state_d = ST_IDLE;
          drop    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Mode is sampled once in CAPT and frozen for the rest of the frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      fx_q       <= '0;
      out_q      <= '0;
      fx_valid_q <= 1'b0;
    end else begin
      fx_valid_q <= 1'b0;
      case (state_q)
        ST_CAPT: begin
          if (mute) begin
            out_q <= '0;
          end else if (bypass) begin
            out_q <= adcfifo_readdata;
          end else begin
            fx_q       <= adcfifo_readdata;
            cnt_q      <= CNT_W'(FX_LATENCY);
            fx_valid_q <= 1'b1;
          end
        end
        ST_FX: begin
          if (cnt_q == '0) begin
            out_q <= fx_out_data;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign adcfifo_read      = (state_q == ST_READ);
  assign fx_in_valid       = fx_valid_q;
  assign fx_in_data        = fx_q;
  assign dacfifo_write     = (state_q == ST_PUSH) && !dacfifo_full;
  assign dacfifo_writedata = out_q;
  assign busy              = (state_q != ST_IDLE);

  sat_counter #(
    .WIDTH(DROP_CNT_W)
  ) u_drop_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (drop),
    .count  (drop_count)
  );

endmodule
